// File: rtl/muldiv_sched_pkg.sv
// Shared encodings for the mul/div scheduler: opcodes, FSM states and the divide-by-zero LO value.
// No logic of its own; imported by the scheduler, its counter and the EX-side interface users.
package muldiv_sched_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// EX-stage side of the mul/div scheduler: request, pipeline control and the HI/LO write port.
// master = EX pipeline, slave = scheduler; stallreq is the only backpressure toward EX.
interface muldiv_sched_if;
  logic        flush;
  logic        stall_ex;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        stallreq;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output flush, stall_ex, req_valid, req_op, req_a, req_b,
    input  stallreq, busy, hilo_we, hi_o, lo_o
  );

  modport slave (
    input  flush, stall_ex, req_valid, req_op, req_a, req_b,
    output stallreq, busy, hilo_we, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_sched_md_lat_cnt.sv
// Loadable down-counter that saturates at zero; times both the multiplier latency and divider watchdog.
// Load takes effect at the next edge; zero is combinational from the count register.
module md_lat_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/muldiv_sched.sv
// Sequences shared multiplier / iterative divider for EX mult/div and emits one HI/LO write per op.
// MUL: MUL_LAT cycles in MUL state; DIV: until div_ready or DIV_TMO; stall_ex holds DONE. MULDIV_EARLY_OUT_EN enables divider bypass.
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_TMO = 40
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_sched_if.slave ex,
  output logic          mul_signed,
  output logic [31:0]   mul_a,
  output logic [31:0]   mul_b,
  input  logic [63:0]   mul_result,
  output logic          div_start,
  output logic          div_annul,
  output logic          div_signed,
  output logic [31:0]   div_a,
  output logic [31:0]   div_b,
  input  logic [63:0]   div_result,
  input  logic          div_ready,
  output logic          div_err
);
  localparam int CNT_MAX = (MUL_LAT > DIV_TMO) ? MUL_LAT : DIV_TMO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_TMO - 1);

  state_e            state, state_nx;
  op_e               op;
  logic              accept, div_zero, early_out, direct_done, tmo;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cap_en;
  logic [63:0]       cap_val;
  logic [31:0]       hi_q, lo_q;

  assign op       = op_e'(ex.req_op);
  assign accept   = (state == ST_IDLE) && ex.req_valid && !ex.flush;
  assign div_zero = (ex.req_b == '0);

`ifdef MULDIV_EARLY_OUT_EN
  // Quotient is trivially zero here and the remainder is the dividend, so hi=a, lo=0.
  assign early_out = ((op == OP_DIVU) && (ex.req_a < ex.req_b)) ||
                     ((op == OP_DIV)  && (ex.req_a == '0));
`else
  assign early_out = 1'b0;
`endif

  assign direct_done  = op_is_div(op) && (div_zero || early_out);
  assign tmo          = (state == ST_DIV) && cnt_zero && !div_ready;
  assign cnt_load_val = op_is_div(op) ? DIV_LOAD : MUL_LOAD;

  md_lat_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (cnt_load_val),
    .dec      ((state == ST_MUL) || (state == ST_DIV)),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nx = state;
    cap_en   = 1'b0;
    cap_val  = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!op_is_div(op)) begin
            state_nx = ST_MUL;
          end else if (direct_done) begin
            state_nx = ST_DONE;
            cap_en   = 1'b1;
            cap_val  = {ex.req_a, (div_zero ? DIVZERO_LO : 32'h0)};
          end else begin
            state_nx = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        if (cnt_zero) begin
          state_nx = ST_DONE;
          cap_en   = 1'b1;
          cap_val  = mul_result;
        end
      end
      ST_DIV: begin
        if (div_ready) begin
          state_nx = ST_DONE;
          cap_en   = 1'b1;
          cap_val  = div_result;
        end else if (cnt_zero) begin
          state_nx = ST_DONE;
          cap_en   = 1'b1;
          cap_val  = '0;
        end
      end
      ST_DONE: begin
        if (!ex.stall_ex) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (ex.flush) begin
      state_nx = ST_IDLE;
      cap_en   = 1'b0;
    end
  end

  assign ex.busy     = (state != ST_IDLE);
  // Drops in DONE so EX can advance in the same cycle the HI/LO write happens.
  assign ex.stallreq = ex.req_valid && !ex.flush && (state != ST_DONE);
  assign ex.hilo_we  = (state == ST_DONE) && !ex.stall_ex && !ex.flush;
  assign ex.hi_o     = hi_q;
  assign ex.lo_o     = lo_q;
  assign div_annul   = (state == ST_DIV) && (ex.flush || tmo);
  assign div_start   = (state == ST_DIV) && !div_annul;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      mul_signed <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      div_signed <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      div_err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (cap_en) {hi_q, lo_q} <= cap_val;
      if (accept && !op_is_div(op)) begin
        mul_signed <= op_is_signed(op);
        mul_a      <= ex.req_a;
        mul_b      <= ex.req_b;
      end
      if (accept && op_is_div(op)) begin
        div_signed <= op_is_signed(op);
        div_a      <= ex.req_a;
        div_b      <= ex.req_b;
      end
      if (tmo && !ex.flush) div_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched with behavioural multiplier/divider models and an HI/LO scoreboard.
module tb_muldiv_sched;
  import muldiv_sched_pkg::*;

  localparam int MUL_LAT       = 2;
  localparam int DIV_TMO       = 40;
  localparam int DIV_MODEL_LAT = 33;

  logic        clk, rst;
  logic        mul_signed, div_start, div_annul, div_signed, div_ready, div_err;
  logic [31:0] mul_a, mul_b, div_a, div_b;
  logic [63:0] mul_result, div_result;

  muldiv_sched_if ex_if();

  muldiv_sched #(.MUL_LAT(MUL_LAT), .DIV_TMO(DIV_TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex         (ex_if),
    .mul_signed (mul_signed),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .div_start  (div_start),
    .div_annul  (div_annul),
    .div_signed (div_signed),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_result (div_result),
    .div_ready  (div_ready),
    .div_err    (div_err)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0, n_err = 0;
  int   n_we = 0, n_start = 0, n_annul = 0, n_sb = 0;
  bit   div_hang = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: one register stage behind the registered operands.
  logic [63:0] mul_pipe = '0;
  always_ff @(posedge clk) begin
    if (mul_signed) mul_pipe <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    else            mul_pipe <= {32'h0, mul_a} * {32'h0, mul_b};
  end
  assign mul_result = mul_pipe;

  // Divider model: ready in the DIV_MODEL_LAT-th consecutive cycle of div_start.
  int dcnt = 0;
  always_ff @(posedge clk) begin
    if (!div_start) dcnt <= 0;
    else            dcnt <= dcnt + 1;
  end
  assign div_ready = div_start && !div_hang && (dcnt == DIV_MODEL_LAT - 1);

  always_comb begin
    div_result = '0;
    if (div_b != 32'h0) begin
      if (div_signed) begin
        div_result[31:0]  = $signed(div_a) / $signed(div_b);
        div_result[63:32] = $signed(div_a) % $signed(div_b);
      end else begin
        div_result[31:0]  = div_a / div_b;
        div_result[63:32] = div_a % div_b;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_write(input string name, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name;
    e.hi   = hi;
    e.lo   = lo;
    sb_q.push_back(e);
  endtask

  // Monitor: scoreboard pops on every HI/LO write; also counts control-strobe cycles.
  always @(negedge clk) begin
    if (!rst) begin
      if (ex_if.hilo_we) begin
        n_we++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_hilo_we: got hi=%h lo=%h, expected no write", ex_if.hi_o, ex_if.lo_o);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, ".hi"}, ex_if.hi_o, e.hi);
          check({e.name, ".lo"}, ex_if.lo_o, e.lo);
        end
      end
      if (div_start) n_start++;
      if (div_annul) n_annul++;
      if (ex_if.stallreq && ex_if.busy) n_sb++;
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int exp_done, input int exp_start, input int exp_sb);
    int s0, sb0, w0, n;
    bit got;
    tick();
    s0  = n_start;
    sb0 = n_sb;
    w0  = n_we;
    expect_write(name, ehi, elo);
    ex_if.req_valid = 1'b1;
    ex_if.req_op    = op;
    ex_if.req_a     = a;
    ex_if.req_b     = b;
    n   = 0;
    got = 0;
    while (!got && n < 200) begin
      tick();
      n++;
      if (n_we != w0) got = 1;
    end
    ex_if.req_valid = 1'b0;
    if (exp_done >= 0) check({name, ".done_cycle"}, got ? n - 1 : -1, exp_done);
    else               check({name, ".completed"}, got, 1);
    if (exp_start >= 0) check({name, ".div_start_cycles"}, n_start - s0, exp_start);
    if (exp_sb >= 0)    check({name, ".stallreq_busy_cycles"}, n_sb - sb0, exp_sb);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int w0, a0, s0, n;
    rst             = 1'b1;
    ex_if.flush     = 1'b0;
    ex_if.stall_ex  = 1'b0;
    ex_if.req_valid = 1'b0;
    ex_if.req_op    = 2'b00;
    ex_if.req_a     = '0;
    ex_if.req_b     = '0;
    repeat (3) tick();
    check("reset.busy",      ex_if.busy, 0);
    check("reset.hilo_we",   ex_if.hilo_we, 0);
    check("reset.hi_o",      ex_if.hi_o, 0);
    check("reset.lo_o",      ex_if.lo_o, 0);
    check("reset.div_start", div_start, 0);
    check("reset.div_err",   div_err, 0);
    check("reset.mul_a",     mul_a, 0);
    rst = 1'b0;

    run_op("multu_ffffffff_2", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, -1, 0, MUL_LAT);
    run_op("mult_m3_5",        2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, -1, 0, MUL_LAT);
    run_op("div_m7_2",         2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 33, -1);
    run_op("div_7_m2",         2'b10, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 34, 33, -1);
    run_op("divu_100_7",       2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34, 33, -1);
    run_op("divu_5_0",         2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 0, -1);
`ifdef MULDIV_EARLY_OUT_EN
    run_op("divu_3_9",         2'b11, 32'd3, 32'd9, 32'd3, 32'd0, 1, 0, -1);
    run_op("div_0_5",          2'b10, 32'd0, 32'd5, 32'd0, 32'd0, 1, 0, -1);
`else
    run_op("divu_3_9",         2'b11, 32'd3, 32'd9, 32'd3, 32'd0, 34, 33, -1);
    run_op("div_0_5",          2'b10, 32'd0, 32'd5, 32'd0, 32'd0, 34, 33, -1);
`endif

    // Downstream stall held for three DONE cycles.
    tick();
    w0 = n_we;
    expect_write("mult_stall", 32'h0, 32'd42);
    ex_if.stall_ex  = 1'b1;
    ex_if.req_valid = 1'b1;
    ex_if.req_op    = 2'b00;
    ex_if.req_a     = 32'd6;
    ex_if.req_b     = 32'd7;
    n = 0;
    while (!(ex_if.busy && !ex_if.stallreq) && n < 50) begin
      tick();
      n++;
    end
    check("stall.reached_done", n < 50, 1);
    for (int i = 0; i < 3; i++) begin
      check("stall.hilo_we_held", ex_if.hilo_we, 0);
      check("stall.lo_stable", ex_if.lo_o, 42);
      tick();
    end
    ex_if.stall_ex = 1'b0;
    tick();
    ex_if.req_valid = 1'b0;
    repeat (2) tick();
    check("stall.write_count", n_we - w0, 1);

    // Flush ten cycles into a divide.
    tick();
    a0 = n_annul;
    w0 = n_we;
    ex_if.req_valid = 1'b1;
    ex_if.req_op    = 2'b11;
    ex_if.req_a     = 32'd100;
    ex_if.req_b     = 32'd7;
    repeat (10) tick();
    ex_if.flush = 1'b1;
    tick();
    ex_if.flush     = 1'b0;
    ex_if.req_valid = 1'b0;
    check("flush_div.busy_after", ex_if.busy, 0);
    repeat (3) tick();
    check("flush_div.annul_cycles", n_annul - a0, 1);
    check("flush_div.write_count", n_we - w0, 0);

    // Flush coincident with a request in IDLE must not launch.
    tick();
    s0 = n_start;
    w0 = n_we;
    ex_if.flush     = 1'b1;
    ex_if.req_valid = 1'b1;
    ex_if.req_op    = 2'b10;
    ex_if.req_a     = 32'd9;
    ex_if.req_b     = 32'd3;
    tick();
    ex_if.flush     = 1'b0;
    ex_if.req_valid = 1'b0;
    check("flush_idle.busy", ex_if.busy, 0);
    repeat (3) tick();
    check("flush_idle.div_start_cycles", n_start - s0, 0);
    check("flush_idle.write_count", n_we - w0, 0);

    // Divider that never answers trips the watchdog.
    check("watchdog.div_err_before", div_err, 0);
    div_hang = 1'b1;
    a0 = n_annul;
    run_op("div_watchdog", 2'b10, 32'd100, 32'd3, 32'h0, 32'h0, DIV_TMO + 1, -1, -1);
    check("watchdog.annul_cycles", n_annul - a0, 1);
    check("watchdog.div_err_after", div_err, 1);
    div_hang = 1'b0;

    repeat (3) tick();
    check("scoreboard.pending", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
